// File: rtl/de_stage_reg.sv
// Decode -> execute stage boundary register.
// Holds one word on the E-side outputs plus a one-entry skid buffer so the
// upstream ready can be a pure register. Supports per-lane flush-to-bubble
// at capture, a whole-stage exception kill, and a saturating count of
// all-bubble words handed to E.
//
// Occupancy FSM:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_EMPTY | main and skid empty, outputs not valid, InReady high
//   ST_MAIN  | main holds a word (OutValid), skid empty, InReady high
//   ST_FULL  | main and skid both hold words, InReady low
module de_stage_reg #(
  parameter int                LANES       = 1,
  parameter int                DATA_W      = 32,
  parameter int                EXC_W       = 5,
  parameter logic [EXC_W-1:0]  EXC_DEFAULT = '0,
  parameter int                CNT_W       = 16
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic [LANES*DATA_W-1:0]   IRD,
  input  logic [LANES*DATA_W-1:0]   PC4D,
  input  logic [LANES*DATA_W-1:0]   RSD,
  input  logic [LANES*DATA_W-1:0]   RTD,
  input  logic [LANES*DATA_W-1:0]   EXTD,
  input  logic [LANES*EXC_W-1:0]    ExcCodeD,
  input  logic [LANES-1:0]          FlushE,
  input  logic                      ExpIn,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic [LANES*DATA_W-1:0]   IRE,
  output logic [LANES*DATA_W-1:0]   PC4E,
  output logic [LANES*DATA_W-1:0]   RSE,
  output logic [LANES*DATA_W-1:0]   RTE,
  output logic [LANES*DATA_W-1:0]   EXTE,
  output logic [LANES*EXC_W-1:0]    ExcCodeE,
  input  logic                      CntClr,
  output logic [CNT_W-1:0]          BubbleCnt
);

  localparam int PW = LANES * DATA_W;
  localparam int EW = LANES * EXC_W;

  typedef struct packed {
    logic [PW-1:0] ir;
    logic [PW-1:0] pc4;
    logic [PW-1:0] rs;
    logic [PW-1:0] rt;
    logic [PW-1:0] ext;
    logic [EW-1:0] exc;
  } payload_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_MAIN  = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  state_t          state_q;
  state_t          state_nxt;
  payload_t        main_q;
  payload_t        skid_q;
  payload_t        idle_p;
  payload_t        in_xf;
  logic            load_main_in;
  logic            load_main_skid;
  logic            load_skid;
  logic            clr_all;
  logic            drain;
  logic            bubble_drain;
  logic [CNT_W-1:0] cnt_q;

  // Cleared payload: everything zero except the "no exception" code per lane.
  always_comb begin
    idle_p = '0;
    for (int i = 0; i < LANES; i++) begin
      idle_p.exc[i*EXC_W +: EXC_W] = EXC_DEFAULT;
    end
  end

  // Incoming word with flushed lanes turned into bubbles; PC4 survives for EPC.
  always_comb begin
    in_xf.ir  = IRD;
    in_xf.pc4 = PC4D;
    in_xf.rs  = RSD;
    in_xf.rt  = RTD;
    in_xf.ext = EXTD;
    in_xf.exc = ExcCodeD;
    for (int i = 0; i < LANES; i++) begin
      if (FlushE[i]) begin
        in_xf.ir [i*DATA_W +: DATA_W] = '0;
        in_xf.rs [i*DATA_W +: DATA_W] = '0;
        in_xf.rt [i*DATA_W +: DATA_W] = '0;
        in_xf.ext[i*DATA_W +: DATA_W] = '0;
        in_xf.exc[i*EXC_W  +: EXC_W]  = EXC_DEFAULT;
      end
    end
  end

  // Occupancy state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next occupancy and payload move strobes; the kill overrides any movement.
  always_comb begin
    state_nxt      = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    clr_all        = 1'b0;
    if (ExpIn) begin
      state_nxt = ST_EMPTY;
      clr_all   = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (InValid) begin
            load_main_in = 1'b1;
            state_nxt    = ST_MAIN;
          end
        end
        ST_MAIN: begin
          if (OutReady) begin
            if (InValid) begin
              load_main_in = 1'b1;
            end else begin
              state_nxt = ST_EMPTY;
            end
          end else if (InValid) begin
            load_skid = 1'b1;
            state_nxt = ST_FULL;
          end
        end
        ST_FULL: begin
          // InReady is low here, so the input is never looked at.
          if (OutReady) begin
            load_main_skid = 1'b1;
            state_nxt      = ST_MAIN;
          end
        end
        default: begin
          state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  // Payload registers; main is held (not cleared) when it simply drains.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      main_q <= idle_p;
      skid_q <= idle_p;
    end else if (clr_all) begin
      main_q <= idle_p;
      skid_q <= idle_p;
    end else begin
      if (load_main_in) begin
        main_q <= in_xf;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_xf;
      end
    end
  end

  assign drain        = (state_q != ST_EMPTY) & OutReady;
  assign bubble_drain = drain & (main_q.ir == '0);

  // Saturating bubble counter; clear wins over increment, kill does not touch it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else if (CntClr) begin
      cnt_q <= '0;
    end else if (bubble_drain && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign InReady   = (state_q != ST_FULL);
  assign OutValid  = (state_q != ST_EMPTY);
  assign IRE       = main_q.ir;
  assign PC4E      = main_q.pc4;
  assign RSE       = main_q.rs;
  assign RTE       = main_q.rt;
  assign EXTE      = main_q.ext;
  assign ExcCodeE  = main_q.exc;
  assign BubbleCnt = cnt_q;

endmodule

// File: tb/tb_de_stage_reg.sv
// Bench for de_stage_reg: directed scenarios followed by a random run, all
// checked every cycle against a queue-based model of the stage contents.
module tb_de_stage_reg;

  localparam int               LANES   = 2;
  localparam int               DATA_W  = 32;
  localparam int               EXC_W   = 5;
  localparam int               CNT_W   = 2;
  localparam logic [EXC_W-1:0] EXC_DEF = 5'd7;
  localparam int               PW      = LANES * DATA_W;
  localparam int               EW      = LANES * EXC_W;
  localparam int               CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [PW-1:0] ir;
    logic [PW-1:0] pc4;
    logic [PW-1:0] rs;
    logic [PW-1:0] rt;
    logic [PW-1:0] ext;
    logic [EW-1:0] exc;
  } word_t;

  logic             Clk;
  logic             Reset_n;
  logic             InValid;
  logic             InReady;
  logic [PW-1:0]    IRD, PC4D, RSD, RTD, EXTD;
  logic [EW-1:0]    ExcCodeD;
  logic [LANES-1:0] FlushE;
  logic             ExpIn;
  logic             OutValid;
  logic             OutReady;
  logic [PW-1:0]    IRE, PC4E, RSE, RTE, EXTE;
  logic [EW-1:0]    ExcCodeE;
  logic             CntClr;
  logic [CNT_W-1:0] BubbleCnt;

  int n_cmp = 0;
  int n_bad = 0;

  word_t q[$];
  word_t last;
  int    cnt_m;

  de_stage_reg #(
    .LANES(LANES), .DATA_W(DATA_W), .EXC_W(EXC_W),
    .EXC_DEFAULT(EXC_DEF), .CNT_W(CNT_W)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .InValid(InValid), .InReady(InReady),
    .IRD(IRD), .PC4D(PC4D), .RSD(RSD), .RTD(RTD), .EXTD(EXTD),
    .ExcCodeD(ExcCodeD), .FlushE(FlushE), .ExpIn(ExpIn),
    .OutValid(OutValid), .OutReady(OutReady),
    .IRE(IRE), .PC4E(PC4E), .RSE(RSE), .RTE(RTE), .EXTE(EXTE),
    .ExcCodeE(ExcCodeE), .CntClr(CntClr), .BubbleCnt(BubbleCnt)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic word_t idle_word();
    word_t w = '0;
    for (int i = 0; i < LANES; i++) w.exc[i*EXC_W +: EXC_W] = EXC_DEF;
    return w;
  endfunction

  // A flushed lane becomes a bubble that keeps only its PC+4.
  function automatic word_t cur_input();
    word_t w;
    w.ir = IRD; w.pc4 = PC4D; w.rs = RSD; w.rt = RTD; w.ext = EXTD; w.exc = ExcCodeD;
    for (int i = 0; i < LANES; i++) begin
      if (FlushE[i]) begin
        w.ir [i*DATA_W +: DATA_W] = '0;
        w.rs [i*DATA_W +: DATA_W] = '0;
        w.rt [i*DATA_W +: DATA_W] = '0;
        w.ext[i*DATA_W +: DATA_W] = '0;
        w.exc[i*EXC_W  +: EXC_W]  = EXC_DEF;
      end
    end
    return w;
  endfunction

  task automatic model_reset();
    q.delete();
    last  = idle_word();
    cnt_m = 0;
  endtask

  // Stage is a FIFO of depth two: ready while it holds fewer than two words.
  task automatic model_step();
    bit ready_m = (q.size() < 2);
    bit drain_m = (q.size() > 0) && OutReady;
    if (CntClr) cnt_m = 0;
    else if (drain_m && q[0].ir == '0 && cnt_m < CNT_MAX) cnt_m++;
    if (ExpIn) begin
      q.delete();
      last = idle_word();
    end else begin
      if (drain_m) last = q.pop_front();
      if (InValid && ready_m) q.push_back(cur_input());
    end
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    word_t e = (q.size() > 0) ? q[0] : last;
    check("OutValid",  128'(OutValid),  128'(q.size() > 0));
    check("InReady",   128'(InReady),   128'(q.size() < 2));
    check("IRE",       128'(IRE),       128'(e.ir));
    check("PC4E",      128'(PC4E),      128'(e.pc4));
    check("RSE",       128'(RSE),       128'(e.rs));
    check("RTE",       128'(RTE),       128'(e.rt));
    check("EXTE",      128'(EXTE),      128'(e.ext));
    check("ExcCodeE",  128'(ExcCodeE),  128'(e.exc));
    check("BubbleCnt", 128'(BubbleCnt), 128'(cnt_m));
  endtask

  task automatic cycle();
    model_step();
    @(posedge Clk);
    #1;
    check_all();
  endtask

  task automatic set_word(input logic [31:0] ir0, input logic [31:0] ir1,
                          input logic [31:0] pc0, input logic [31:0] pc1);
    IRD      = {ir1, ir0};
    PC4D     = {pc1, pc0};
    RSD      = {ir1 ^ 32'h1111_1111, ir0 ^ 32'h2222_2222};
    RTD      = {pc1 ^ 32'h3333_3333, pc0 ^ 32'h4444_4444};
    EXTD     = {ir1 + 32'd5, ir0 + 32'd9};
    ExcCodeD = {5'h11, 5'h12};
    FlushE   = '0;
  endtask

  task automatic rand_word();
    bit bubble = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < LANES; i++) begin
      IRD [i*DATA_W +: DATA_W] = bubble ? 32'd0 : $urandom;
      PC4D[i*DATA_W +: DATA_W] = $urandom;
      RSD [i*DATA_W +: DATA_W] = $urandom;
      RTD [i*DATA_W +: DATA_W] = $urandom;
      EXTD[i*DATA_W +: DATA_W] = $urandom;
      ExcCodeD[i*EXC_W +: EXC_W] = EXC_W'($urandom);
      FlushE[i] = ($urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    Reset_n = 1'b0; InValid = 1'b0; OutReady = 1'b0; ExpIn = 1'b0; CntClr = 1'b0;
    set_word(32'd0, 32'd0, 32'd0, 32'd0);
    model_reset();
    #12;
    check_all();
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    // first word, 1-cycle latency
    set_word(32'h8C22_0004, 32'h0085_1020, 32'h3004, 32'h3008);
    InValid = 1'b1; OutReady = 1'b1;
    cycle();
    check("first_ir", 128'(IRE[31:0]), 128'(32'h8C22_0004));
    check("first_pc", 128'(PC4E[31:0]), 128'(32'h3004));

    // back-to-back stream of 8 words
    for (int k = 0; k < 8; k++) begin
      set_word(32'h1000_0000 + 32'(k), 32'h2000_0000 + 32'(k), 32'h4000 + 32'(4*k), 32'h5000 + 32'(4*k));
      cycle();
    end
    InValid = 1'b0;
    cycle();
    cycle();

    // stall with A, B, C offered continuously
    OutReady = 1'b0; InValid = 1'b1;
    set_word(32'hA, 32'hA1, 32'h100, 32'h104); cycle();
    set_word(32'hB, 32'hB1, 32'h108, 32'h10C); cycle();
    set_word(32'hC, 32'hC1, 32'h110, 32'h114); cycle();
    check("stall_hold_a", 128'(IRE[31:0]), 128'(32'hA));
    check("stall_inready", 128'(InReady), 128'(1'b0));
    OutReady = 1'b1;
    cycle();
    cycle();
    InValid = 1'b0;
    cycle();
    cycle();

    // per-lane flush on lane 1
    set_word(32'h8C22_0004, 32'h0085_1020, 32'h3004, 32'h3008);
    FlushE = 2'b10; InValid = 1'b1;
    cycle();
    check("flush_ir1",  128'(IRE[63:32]), 128'(32'd0));
    check("flush_pc1",  128'(PC4E[63:32]), 128'(32'h3008));
    check("flush_exc1", 128'(ExcCodeE[9:5]), 128'(EXC_DEF));
    check("flush_ir0",  128'(IRE[31:0]), 128'(32'h8C22_0004));
    InValid = 1'b0; FlushE = '0;
    cycle();

    // kill with main and skid full
    OutReady = 1'b0; InValid = 1'b1;
    set_word(32'h51, 32'h52, 32'h200, 32'h204); cycle();
    set_word(32'h61, 32'h62, 32'h208, 32'h20C); cycle();
    ExpIn = 1'b1;
    set_word(32'h71, 32'h72, 32'h210, 32'h214);
    cycle();
    check("kill_valid", 128'(OutValid), 128'(1'b0));
    check("kill_ready", 128'(InReady), 128'(1'b1));
    check("kill_ir",    128'(IRE), 128'(0));
    ExpIn = 1'b0; InValid = 1'b0;
    cycle();

    // bubble counter saturation, then clear racing an increment
    OutReady = 1'b1; CntClr = 1'b1;
    cycle();
    CntClr = 1'b0; InValid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_word(32'd0, 32'd0, 32'h300 + 32'(8*k), 32'h304 + 32'(8*k));
      cycle();
    end
    InValid = 1'b0;
    cycle();
    check("bubble_sat", 128'(BubbleCnt), 128'(2'd3));
    InValid = 1'b1;
    set_word(32'd0, 32'd0, 32'h400, 32'h404);
    cycle();
    InValid = 1'b0; CntClr = 1'b1;
    cycle();
    check("bubble_clr", 128'(BubbleCnt), 128'(0));
    CntClr = 1'b0;

    // async reset between edges in the middle of a stall
    OutReady = 1'b0; InValid = 1'b1;
    set_word(32'h81, 32'h82, 32'h500, 32'h504); cycle();
    set_word(32'h91, 32'h92, 32'h508, 32'h50C); cycle();
    #3 Reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #1 Reset_n = 1'b1;
    InValid = 1'b0;
    cycle();

    // random traffic
    for (int k = 0; k < 400; k++) begin
      InValid  = ($urandom_range(0, 3) != 0);
      OutReady = ($urandom_range(0, 9) < 7);
      ExpIn    = ($urandom_range(0, 19) == 0);
      CntClr   = ($urandom_range(0, 24) == 0);
      rand_word();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
